// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer interface: pipeline-side hazard/memory inputs and the
// hold/flush/bubble/freeze controls returned to the pipeline registers.
//   master : pipeline side (drives register numbers and control flags, receives controls)
//   slave  : hazard_sequencer (receives flags, drives controls)
interface hazard_sequencer_if;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic [4:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [4:0] mem_dest;
  logic       mem_wb_en;
  logic       exe_br_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic       idexe_bubble;
  logic       pipe_freeze;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, exe_br_taken, mem_req, mem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idexe_bubble, pipe_freeze
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, exe_br_taken, mem_req, mem_ready,
    output pc_hold, ifid_hold, ifid_flush, idexe_bubble, pipe_freeze
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard and stall sequencer for the 5-stage MIPS core.
// Decides PC/IF-ID hold, IF-ID flush, ID-EXE bubble and whole-pipe freeze
// for slow data-memory accesses, with a timeout to a sticky error state.
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-low
//   hif        hazard_sequencer_if.slave (hazard inputs, pipeline controls)
//   mem_err    sticky memory-timeout error
//   state      FSM state: 0 RUN, 1 MEM_WAIT, 2 MEM_ERR
//   stall_cnt  saturating count of cycles with pc_hold
//   flush_cnt  saturating count of cycles with ifid_flush
module hazard_sequencer #(
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_sequencer_if.slave hif,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t        cur, nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          frozen;
  logic          raw_exe, raw_mem, hazard;
  logic          pc_hold_c, ifid_hold_c, ifid_flush_c, idexe_bubble_c, pipe_freeze_c;

  // R0 is hard-wired zero, so a write to it never creates a dependency.
  assign raw_exe = hif.exe_wb_en && (hif.exe_dest != 5'd0) &&
                   ((hif.exe_dest == hif.id_src1) ||
                    (hif.id_two_src && (hif.exe_dest == hif.id_src2)));
  assign raw_mem = hif.mem_wb_en && (hif.mem_dest != 5'd0) &&
                   ((hif.mem_dest == hif.id_src1) ||
                    (hif.id_two_src && (hif.mem_dest == hif.id_src2)));
  assign hazard  = FWD_EN ? (raw_exe && hif.exe_mem_r_en) : (raw_exe || raw_mem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur       <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (pc_hold_c && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush_c && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt            = cur;
    wait_nxt       = wait_cnt;
    frozen         = 1'b0;
    pc_hold_c      = 1'b0;
    ifid_hold_c    = 1'b0;
    ifid_flush_c   = 1'b0;
    idexe_bubble_c = 1'b0;
    pipe_freeze_c  = 1'b0;

    unique case (cur)
      RUN: begin
        if (hif.mem_req && !hif.mem_ready) begin
          frozen   = 1'b1;
          nxt      = MEM_WAIT;
          wait_nxt = WW'(1);
        end
      end
      MEM_WAIT: begin
        // mem_ready releases the freeze in the completing cycle itself.
        if (hif.mem_ready) begin
          nxt = RUN;
        end else begin
          frozen = 1'b1;
          if (wait_cnt == WW'(TIMEOUT - 1))
            nxt = MEM_ERR;
          else
            wait_nxt = wait_cnt + WW'(1);
        end
      end
      MEM_ERR: frozen = 1'b1;
      default: nxt = RUN;
    endcase

    // A frozen ID/EXE still holds the taken branch, so it is flushed later.
    if (frozen) begin
      pipe_freeze_c = 1'b1;
      pc_hold_c     = 1'b1;
      ifid_hold_c   = 1'b1;
    end else if (hif.exe_br_taken) begin
      ifid_flush_c   = 1'b1;
      idexe_bubble_c = 1'b1;
    end else if (hazard) begin
      pc_hold_c      = 1'b1;
      ifid_hold_c    = 1'b1;
      idexe_bubble_c = 1'b1;
    end
  end

  assign hif.pc_hold      = pc_hold_c;
  assign hif.ifid_hold    = ifid_hold_c;
  assign hif.ifid_flush   = ifid_flush_c;
  assign hif.idexe_bubble = idexe_bubble_c;
  assign hif.pipe_freeze  = pipe_freeze_c;
  assign mem_err          = (cur == MEM_ERR);
  assign state            = cur;
endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It decides each cycle whether the PC and IF/ID register hold, whether IF/ID is flushed, whether a bubble (all control zeroed) is loaded into the ID/EXE register, and whether the whole pipeline freezes for a slow memory access. It sits beside the ID stage, reads register numbers from ID and control bits from the EXE and MEM pipeline registers, and drives the hold/flush/bubble controls of the PC and the IF/ID, ID/EXE and EXE/MEM pipeline registers.

## Interface
- FWD_EN, 1: 1 = forwarding unit present, only load-use stalls; 0 = stall on any RAW against EXE or MEM.
- TIMEOUT, 16: maximum frozen cycles without mem_ready before error (>= 2).
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- id_src1, id_src2  in  5  source registers of the instruction in ID.
- id_two_src  in  1  instruction reads id_src2.
- exe_dest  in  5  destination register in ID/EXE.
- exe_wb_en, exe_mem_r_en  in  1  write-back and load flags in ID/EXE.
- mem_dest  in  5  destination register in EXE/MEM.
- mem_wb_en  in  1  write-back flag in EXE/MEM.
- exe_br_taken  in  1  branch resolved taken in EXE.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold, ifid_hold  out  1  PC and IF/ID keep their value.
- ifid_flush  out  1  IF/ID loads a NOP.
- idexe_bubble  out  1  ID/EXE loads zeroed control (NOP).
- pipe_freeze  out  1  ID/EXE and EXE/MEM keep their value.
- mem_err  out  1  sticky memory-timeout error.
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 MEM_ERR.
- stall_cnt, flush_cnt  out  CNT_W  saturating statistics.

## Operation
- Hazard terms (R0 never hazards): raw_x = x_wb_en & (x_dest != 0) & (x_dest == id_src1 | id_two_src & x_dest == id_src2), for x = exe and mem.
- FWD_EN=1: hazard = raw_exe & exe_mem_r_en. FWD_EN=0: hazard = raw_exe | raw_mem.
- frozen = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready) | MEM_ERR.
- Output priority is freeze > branch > hazard:
  - frozen: pipe_freeze, pc_hold and ifid_hold are 1. ifid_flush and idexe_bubble are 0, because the held ID/EXE keeps exe_br_taken for later.
  - else exe_br_taken: ifid_flush and idexe_bubble are 1. pc_hold and ifid_hold are 0, so the PC loads the target.
  - else hazard: pc_hold, ifid_hold and idexe_bubble are 1.
  - else all 0.
- FSM:
  - RUN -> MEM_WAIT on mem_req & !mem_ready; wait_cnt <= 1.
  - MEM_WAIT & mem_ready -> RUN. The freeze drops in that same cycle.
  - MEM_WAIT & !mem_ready: if wait_cnt == TIMEOUT-1, go to MEM_ERR; else wait_cnt <= wait_cnt+1.
  - MEM_ERR is terminal until reset. mem_err = (state == MEM_ERR).
- stall_cnt increments in every cycle with pc_hold=1. flush_cnt increments in every cycle with ifid_flush=1. Both saturate at 2^CNT_W-1.

## Timing
- Reset (rst=0 at a posedge) sets state RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0. The asynchronous rst level does not gate the outputs; the control outputs are combinational from the reset state and inputs. rst=0 during MEM_WAIT or MEM_ERR returns to RUN at that edge.
- All control outputs are combinational from current inputs and state, with no added latency. A hazard bubble lasts exactly as long as the hazard term is true; with FWD_EN=1, a load-use costs 1 cycle.
- A mem_req answered by mem_ready in the same cycle causes no freeze and no state change.
- Maximum freeze is TIMEOUT cycles, counting the first RUN cycle. MEM_ERR is entered at the following edge.
- Counter updates are registered: they become visible one cycle after the qualifying cycle.

## Test plan
- FWD_EN=1, load r5 in EXE (exe_mem_r_en=1, exe_dest=5), ID reads id_src1=5 -> pc_hold, ifid_hold and idexe_bubble are 1 for 1 cycle; stall_cnt reads 1 afterwards. With exe_mem_r_en=0 -> no stall.
- FWD_EN=0, mem_dest=7, mem_wb_en=1, id_two_src=1, id_src2=7 -> stall. With id_two_src=0 -> no stall. With dest=0 and src=0 -> never stall.
- exe_br_taken=1 together with a load-use hazard -> ifid_flush=1, idexe_bubble=1, pc_hold=0; flush_cnt increments by 1.
- mem_req=1 with mem_ready low for 3 cycles, high on the 4th, while exe_br_taken=1 -> pipe_freeze is 1 for 3 cycles and no flush during them; the flush occurs on the 4th cycle; state sequence is 0,1,1,1 then 0.
- TIMEOUT=4, mem_ready held low -> freeze for 4 cycles, then state=2 and mem_err=1 sticky; rst=0 for one edge -> state 0, counters 0, mem_err 0.
- stall_cnt saturation (CNT_W=4) -> holds at 15 under continuous stall.
